if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipeline. Holds the program counter and drives the word-indexed instruction memory's combinational read port. Captures the returned instruction into the IF/ID pipeline register. Handles decode-stage stalls and branch/jump redirects from execute, inserting canonical NOP bubbles (`32'h00000013`) on flush.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be 4-byte aligned.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  hold PC and IF/ID contents (load-use hazard from decode).
- `redirect_i`  in  1  redirect fetch to `redirect_pc_i` and flush IF/ID.
- `redirect_pc_i`  in  32  redirect target byte address.
- `imem_addr_o`  out  32  byte address to instruction memory; equals the PC register.
- `imem_instr_i`  in  32  instruction word returned combinationally for `imem_addr_o`.
- `id_valid_o`  out  1  IF/ID entry holds a real instruction.
- `id_pc_o`  out  32  PC of the IF/ID instruction.
- `id_pc4_o`  out  32  `id_pc_o + 4`, for link-register writes.
- `id_instr_o`  out  32  instruction word, or NOP when invalid.
- `id_misalign_o`  out  1  entry was fetched from a force-aligned, misaligned redirect target.
- `perf_fetch_o`, `perf_stall_o`, `perf_flush_o`  out  32 each  performance counters; present only with `IF_PERF_CNT_EN`.

## Operation
- Priority at each rising edge: `rst` > `redirect_i` > `stall_i` > normal advance.
- Reset:
  - `pc <= RESET_PC`, `misalign_pend <= 0`.
  - IF/ID is set to a bubble: valid 0, pc 0, pc4 0, instr `32'h00000013`, misalign 0.
  - Counters are set to 0.
- Redirect:
  - `pc <= {redirect_pc_i[31:2], 2'b00}`.
  - `misalign_pend <= |redirect_pc_i[1:0]`.
  - IF/ID is set to a bubble.
  - The redirect overrides a simultaneous stall; the stalled instruction is discarded.
- Stall (no redirect): PC, `misalign_pend` and IF/ID all hold their values.
- Advance:
  - IF/ID captures `{1, pc, pc+4, imem_instr_i, misalign_pend}`.
  - `pc <= pc + 4`.
  - `misalign_pend <= 0`.
- Arithmetic: all 32-bit, modulo 2^32. `pc + 4` at `32'hFFFF_FFFC` wraps to `0`. No memory bounds check; address aliasing is the memory's concern.
- `imem_addr_o` is driven directly from the PC register, never from the next-PC logic, so there is no combinational path from `redirect_i` or `stall_i` to `imem_addr_o`.
- Every output is registered except `imem_addr_o`, which is a direct PC-register read.

## Timing
- Fetch latency: one cycle. An instruction at PC p appears on the `id_*` outputs the edge after the edge at which `imem_addr_o = p`.
- After reset:
  - First non-reset edge: `id_valid_o = 1` with `id_pc_o = RESET_PC`.
  - Before that edge, `id_valid_o = 0`.
- Redirect asserted before edge N:
  - After N: `id_valid_o = 0`, `imem_addr_o` = target.
  - After N+1: `id_pc_o` = target, `id_valid_o = 1`.
  - Redirect penalty is one IF bubble. Flushing the decode stage is the hazard unit's job.
- Back-to-back redirects: the last one wins. The bubble is held and no intermediate target is fetched.
- Stall held k cycles: the `id_*` outputs stay constant for k edges, and `imem_addr_o` is constant.
- Reset mid-stall or mid-redirect: reset wins, with the same state as a cold reset.

## Configuration
- Macro `IF_PERF_CNT_EN`. When defined, the block adds three 32-bit wrapping counters, each incrementing at the edge where its condition holds and `rst` is low:
  - `perf_fetch_o`: advance taken.
  - `perf_stall_o`: stall without redirect.
  - `perf_flush_o`: redirect.
- Without the macro, the counters and their ports are absent and behaviour is otherwise identical.

## Structure
- Shared pipeline package `pipe_pkg` holds:
  - `NOP_INSTR = 32'h00000013`;
  - the `if_id_t` struct `{valid, pc, pc4, instr, misalign}`;
  - `IF_ID_BUBBLE`, the reset/flush value of `if_id_t`.
- One natural sub-module, `pc_gen`: PC register, `misalign_pend`, next-PC mux and priority logic.
- `if_stage` itself contains the IF/ID register and the optional counters.

## Test plan
- Reset with `RESET_PC = 0`, memory words 0..2 = `01400313`, `00602023`, `00000013` -> over three edges, `id_pc_o` = 0, 4, 8; `id_instr_o` matches each word; `id_valid_o = 1`.
- `stall_i` high for 3 cycles while `id_pc_o = 4` -> `id_*` outputs constant and `imem_addr_o = 8` throughout; resumes with `id_pc_o = 8`.
- `redirect_i` with `redirect_pc_i = 32'h20` and `stall_i` high in the same cycle -> next edge bubble (`id_valid_o = 0`, `id_instr_o = 32'h00000013`); following edge `id_pc_o = 32'h20`.
- Redirect to `32'h22` -> fetch from `32'h20`; that entry has `id_misalign_o = 1`, and the following entry (`32'h24`) has 0.
- Redirect to `32'hFFFF_FFFC`, then advance -> `id_pc_o = 32'hFFFF_FFFC`, `id_pc4_o = 0`, next `id_pc_o = 0`.
- With `IF_PERF_CNT_EN`: 5 advances, 2 stalls, 1 redirect after reset -> counters read 5 / 2 / 1; asserting `rst` clears all three to 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the five-stage core: the canonical NOP, the
// IF/ID register layout and its reset/flush value.
package pipe_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        misalign;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        valid:    1'b0,
        pc:       32'h0,
        pc4:      32'h0,
        instr:    NOP_INSTR,
        misalign: 1'b0
    };

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// pc_gen: program counter, pending-misalign flag and the next-PC
// priority mux (reset > redirect > stall > sequential advance).
module pc_gen
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        misalign_pend_o,
    output logic        advance_o
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_pend_q, misalign_pend_d;
    logic [31:0] pc4;

    // Wraps modulo 2^32 by construction.
    assign pc4 = pc_q + 32'd4;

    // Next-PC selection; redirect overrides a simultaneous stall.
    always_comb begin
        pc_d            = pc_q;
        misalign_pend_d = misalign_pend_q;
        advance_o       = 1'b0;
        if (redirect_i) begin
            pc_d            = word_align(redirect_pc_i);
            misalign_pend_d = |redirect_pc_i[1:0];
        end else if (!stall_i) begin
            pc_d            = pc4;
            misalign_pend_d = 1'b0;
            advance_o       = 1'b1;
        end
    end

    // PC and misalign flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= RESET_PC;
            misalign_pend_q <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            misalign_pend_q <= misalign_pend_d;
        end
    end

    // The memory address comes straight off the register, never from pc_d.
    assign pc_o            = pc_q;
    assign pc4_o           = pc4;
    assign misalign_pend_o = misalign_pend_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Drives the instruction memory from the PC
// register and captures the returned word into the IF/ID register,
// inserting NOP bubbles on redirect.
// Optional feature macro: IF_PERF_CNT_EN adds fetch/stall/flush counters.
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_flush_o,
`endif
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic [31:0] id_instr_o,
    output logic        id_misalign_o
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        misalign_pend;
    logic        advance;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .pc_o            (pc),
        .pc4_o           (pc4),
        .misalign_pend_o (misalign_pend),
        .advance_o       (advance)
    );

    assign imem_addr_o = pc;

    if_id_t if_id_q, if_id_d;

    // IF/ID next value: flush to bubble on redirect, hold on stall, else capture.
    always_comb begin
        if_id_d = if_id_q;
        if (redirect_i) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (advance) begin
            if_id_d.valid    = 1'b1;
            if_id_d.pc       = pc;
            if_id_d.pc4      = pc4;
            if_id_d.instr    = imem_instr_i;
            if_id_d.misalign = misalign_pend;
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign id_valid_o    = if_id_q.valid;
    assign id_pc_o       = if_id_q.pc;
    assign id_pc4_o      = if_id_q.pc4;
    assign id_instr_o    = if_id_q.instr;
    assign id_misalign_o = if_id_q.misalign;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Event counters; each wraps freely at 2^32.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (redirect_i) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end else if (stall_i) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
    assign perf_flush_o = perf_flush_q;
`endif

endmodule
